// File: rtl/port_io_pkg.sv
// Shared defaults and sizing helpers for the port I/O unit.
package port_io_pkg;
    localparam int DATA_W_DEF    = 16;
    localparam int OUT_DEPTH_DEF = 4;
    localparam int PTR_W         = $clog2(OUT_DEPTH_DEF);

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/port_io_unit_fifo.sv
// port_sync_fifo: power-of-two synchronous FIFO; a full queue still accepts a push when it pops in the same cycle.
module port_sync_fifo
    import port_io_pkg::*;
#(
    parameter int W     = DATA_W_DEF,
    parameter int DEPTH = OUT_DEPTH_DEF,
    localparam int PW   = ptr_w(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage is never cleared; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/port_io_unit.sv
// Processor port I/O: queued OUT path toward the device, single-word IN holding register.
// Optional PORT_IO_STATS_EN adds a saturating out_count of device pops.
module port_io_unit
    import port_io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_out_we,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              cpu_stall,
    input  logic              cpu_in_re,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_valid,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
`ifdef PORT_IO_STATS_EN
    output logic [15:0]       out_count,
`endif
    output logic              ext_in_ready
);
    localparam int CW = ptr_w(OUT_DEPTH) + 1;

    logic              full;
    logic              empty;
    logic [CW-1:0]     fill;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              push;
    logic              capture;

    assign ext_out_valid = (fill != '0);
    assign ext_out_data  = empty ? '0 : head;
    assign pop           = ext_out_valid & ext_out_ready;
    assign cpu_stall     = cpu_out_we & full & ~pop;
    assign push          = cpu_out_we & ~cpu_stall;

    port_sync_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cpu_out_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fill)
    );

    assign ext_in_ready = ~reset & (~cpu_in_valid | cpu_in_re);
    assign capture      = ext_in_valid & ext_in_ready;

    // A capture wins over a same-cycle read so the fresh word stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_in_data  <= '0;
            cpu_in_valid <= 1'b0;
        end else begin
            if (capture) cpu_in_data <= ext_in_data;
            if (capture)        cpu_in_valid <= 1'b1;
            else if (cpu_in_re) cpu_in_valid <= 1'b0;
        end
    end

`ifdef PORT_IO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) out_count <= '0;
        else if (pop && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_port_io_unit.sv
// Directed table-driven bench for port_io_unit plus hand-written streaming and stats sequences.
module tb_port_io_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_out_we;
    logic [15:0] cpu_out_data;
    logic        cpu_stall;
    logic        cpu_in_re;
    logic [15:0] cpu_in_data;
    logic        cpu_in_valid;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
`ifdef PORT_IO_STATS_EN
    logic [15:0] out_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    port_io_unit #(.DATA_W(16), .OUT_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_out_we    (cpu_out_we),
        .cpu_out_data  (cpu_out_data),
        .cpu_stall     (cpu_stall),
        .cpu_in_re     (cpu_in_re),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_valid  (cpu_in_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
`ifdef PORT_IO_STATS_EN
        .out_count     (out_count),
`endif
        .ext_in_ready  (ext_in_ready)
    );

    typedef struct {
        logic        rst, we;
        logic [15:0] wd;
        logic        re, ordy, ivld;
        logic [15:0] id;
        logic        stall, irdy;      // before the edge
        logic        ovld;             // after the edge
        logic [15:0] odata;
        logic        cvld;
        logic [15:0] cdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic we, logic [15:0] wd, logic re, logic ordy,
                                logic ivld, logic [15:0] id, logic stall, logic irdy,
                                logic ovld, logic [15:0] odata, logic cvld, logic [15:0] cdata);
        vec_t v;
        v.rst = rst; v.we = we; v.wd = wd; v.re = re; v.ordy = ordy; v.ivld = ivld; v.id = id;
        v.stall = stall; v.irdy = irdy; v.ovld = ovld; v.odata = odata; v.cvld = cvld; v.cdata = cdata;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [15:0] wd, input logic re,
                         input logic ordy, input logic ivld, input logic [15:0] id);
        reset = rst; cpu_out_we = we; cpu_out_data = wd; cpu_in_re = re;
        ext_out_ready = ordy; ext_in_valid = ivld; ext_in_data = id;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        //        rst we wd        re ordy ivld id        stall irdy ovld odata     cvld cdata
        vq.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
        vq.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));
        // back-to-back writes drain on consecutive cycles
        vq.push_back(mk(0, 1, 16'h00DA, 0, 1, 0, 16'h0000, 0, 1, 1, 16'h00DA, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'h1234, 0, 1, 0, 16'h0000, 0, 1, 1, 16'h1234, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));
        // fill to depth, stall on the 5th, then accept it alongside a pop
        vq.push_back(mk(0, 1, 16'hA001, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hA001, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hA002, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hA001, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hA003, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hA001, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hA004, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hA001, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hA005, 0, 0, 0, 16'h0000, 1, 1, 1, 16'hA001, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hA005, 0, 1, 0, 16'h0000, 0, 1, 1, 16'hA002, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 1, 16'hA003, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 1, 16'hA004, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 1, 16'hA005, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));
        // input register: capture, hold off, read-and-capture, empty read
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 0, 1, 0, 16'h0000, 1, 16'hBEEF));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'hCAFE, 0, 0, 0, 16'h0000, 1, 16'hBEEF));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hCAFE, 0, 1, 0, 16'h0000, 1, 16'hCAFE));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'hCAFE));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'hCAFE));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h1111, 0, 1, 0, 16'h0000, 1, 16'h1111));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0055, 0, 1, 0, 16'h0000, 1, 16'h0055));
        vq.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0055));
        // reset mid-transfer discards queue and blocks capture
        vq.push_back(mk(0, 1, 16'hB001, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hB001, 0, 16'h0055));
        vq.push_back(mk(0, 1, 16'hB002, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hB001, 0, 16'h0055));
        vq.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h7777, 0, 1, 1, 16'hB001, 1, 16'h7777));
        vq.push_back(mk(1, 1, 16'hB003, 0, 1, 1, 16'h8888, 0, 0, 0, 16'h0000, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));
        vq.push_back(mk(0, 1, 16'hC001, 0, 0, 0, 16'h0000, 0, 1, 1, 16'hC001, 0, 16'h0000));
        vq.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].we, vq[i].wd, vq[i].re, vq[i].ordy, vq[i].ivld, vq[i].id);
            #1;
            chk("cpu_stall", i, 16'(cpu_stall), 16'(vq[i].stall));
            chk("ext_in_ready", i, 16'(ext_in_ready), 16'(vq[i].irdy));
            step();
            chk("ext_out_valid", i, 16'(ext_out_valid), 16'(vq[i].ovld));
            if (vq[i].ovld) chk("ext_out_data", i, ext_out_data, vq[i].odata);
            chk("cpu_in_valid", i, 16'(cpu_in_valid), 16'(vq[i].cvld));
            chk("cpu_in_data", i, cpu_in_data, vq[i].cdata);
        end

        // continuous streaming across several pointer wraps: each word appears right after its push
        for (int k = 0; k < 9; k++) begin
            drive(0, 1, 16'h5000 + 16'(k), 0, 1, 0, 0);
            #1;
            chk("stream_stall", k, 16'(cpu_stall), 16'h0);
            step();
            chk("stream_valid", k, 16'(ext_out_valid), 16'h1);
            chk("stream_data", k, ext_out_data, 16'h5000 + 16'(k));
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        chk("stream_drained", 0, 16'(ext_out_valid), 16'h0);

`ifdef PORT_IO_STATS_EN
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("out_count_reset", 0, out_count, 16'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 16'h6000 + 16'(k), 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        repeat (4) step();
        chk("out_count_three", 0, out_count, 16'd3);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("out_count_cleared", 0, out_count, 16'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/port_io_unit.md
PORT_IO_UNIT -- requirements
Module: port_io_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning port word width.
REQ-002 SHALL have parameter OUT_DEPTH, default 4, meaning output FIFO entries; power of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cpu_out_we, input, 1, processor OUT-instruction write strobe.
REQ-006 SHALL have port cpu_out_data, input, DATA_W, processor OUT word.
REQ-007 SHALL have port cpu_stall, output, 1, write back-pressure to processor.
REQ-008 SHALL have port cpu_in_re, input, 1, processor IN-instruction read strobe.
REQ-009 SHALL have port cpu_in_data, output, DATA_W, word presented to the processor portIn.
REQ-010 SHALL have port cpu_in_valid, output, 1, unread input word pending.
REQ-011 SHALL have port ext_out_data, output, DATA_W, FIFO head toward the device.
REQ-012 SHALL have port ext_out_valid, output, 1, FIFO head valid.
REQ-013 SHALL have port ext_out_ready, input, 1, device accepts the head.
REQ-014 SHALL have port ext_in_data, input, DATA_W, device word.
REQ-015 SHALL have port ext_in_valid, input, 1, device word valid.
REQ-016 SHALL have port ext_in_ready, output, 1, unit can capture a device word.

Function
REQ-017 Output path SHALL push cpu_out_data when cpu_out_we=1 and FIFO not full.
REQ-018 cpu_stall SHALL be combinational: cpu_out_we & full & ~(ext_out_valid & ext_out_ready).
REQ-019 Full FIFO with a pop in the same cycle SHALL accept the push; count is unchanged.
REQ-020 ext_out_valid SHALL be 1 iff count>0; a word pushed at edge N SHALL be visible after edge N.
REQ-021 Pop SHALL occur on ext_out_valid & ext_out_ready; ordering SHALL be strict FIFO.
REQ-022 Read and write pointers SHALL wrap modulo OUT_DEPTH; count SHALL range 0..OUT_DEPTH.
REQ-023 Push with cpu_out_we=1 while stalled SHALL be dropped; the processor holds and retries.
REQ-024 The input holding register SHALL capture ext_in_data when ext_in_valid & ext_in_ready.
REQ-025 ext_in_ready SHALL be ~cpu_in_valid | cpu_in_re, forced 0 while reset=1.
REQ-026 cpu_in_data SHALL hold the last captured word (sticky) until the next capture.
REQ-027 cpu_in_valid SHALL set on capture, clear on cpu_in_re, and stay 1 when both occur in the same cycle.
REQ-028 cpu_in_re while cpu_in_valid=0 SHALL have no effect; cpu_in_data is unchanged.

Reset
REQ-029 On reset=1 at an edge, the FIFO SHALL empty: pointers 0, count 0, ext_out_valid 0.
REQ-030 Reset SHALL set cpu_in_data 0 and cpu_in_valid 0.
REQ-031 Reset mid-transfer SHALL discard queued words; no pop or capture SHALL occur in that cycle.
REQ-032 FIFO storage contents SHALL need no reset.

Configuration
REQ-033 Macro PORT_IO_STATS_EN: when defined, the unit SHALL add output out_count [15:0].
REQ-034 out_count SHALL increment on each ext pop, saturate at 16'hFFFF, and reset to 0.
REQ-035 When PORT_IO_STATS_EN is undefined, out_count SHALL not exist and no counter logic SHALL be generated.

Structure
REQ-036 Package port_io_pkg SHALL hold DATA_W and OUT_DEPTH defaults and the pointer-width constant (clog2 of OUT_DEPTH).
REQ-037 The output queue SHALL be sub-module port_sync_fifo (push/pop/full/empty/count); the input register stays inline.

Verification
REQ-038 Reset for 2 cycles, release -> ext_out_valid=0, cpu_in_valid=0, cpu_in_data=0, ext_in_ready=1.
REQ-039 Write 16'h00DA, 16'h1234, ext_out_ready=1 -> ext_out_data shows 00DA then 1234 on consecutive cycles.
REQ-040 ext_out_ready=0, 5 writes at default depth -> 4 accepted, cpu_stall=1 on 5th; then ready=1 -> 5th accepted the same cycle.
REQ-041 ext_in 16'hBEEF captured, no read -> ext_in_ready=0; second device word held off; cpu_in_re -> BEEF read, next word captured.
REQ-042 cpu_in_re and capture of 16'h0055 in the same cycle -> cpu_in_valid stays 1, cpu_in_data=0055.
REQ-043 PORT_IO_STATS_EN defined, 3 pops then reset -> out_count 3, then 0.
